// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one 32-bit adder among N requesters and
// returns each tagged 33-bit sum through a single-entry, drain-and-refill output register.

module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [32:0] sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [32*N-1:0]   req_a,
  input  logic [32*N-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [32:0]       rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [IDW-1:0]   last_grant_reg;
  logic [32:0]      rsp_sum_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [15:0]      op_count_reg;

  logic [31:0]      a_arr [N];
  logic [31:0]      b_arr [N];
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW:0]     cand_sum;
  logic             can_accept;
  logic             fire;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [32:0]      adder_sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // Scan last_grant+1 .. last_grant+N (mod N); the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, last_grant_reg} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(N))
        cand_sum = cand_sum - (IDW+1)'(N);
      if (!win_found && req_valid[cand_sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand_sum[IDW-1:0];
      end
    end
  end

  assign can_accept = (state_reg == EMPTY) || rsp_ready;
  assign fire       = rst && win_found && can_accept;

  always_comb begin
    req_ready = '0;
    if (fire)
      req_ready[win_id] = 1'b1;
  end

  assign sel_a = a_arr[win_id];
  assign sel_b = b_arr[win_id];

  adder32 u_adder (
    .a   (sel_a),
    .b   (sel_b),
    .sum (adder_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state_reg <= EMPTY;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (fire) state_next = FULL;
      FULL: begin
        if (fire)
          state_next = FULL;
        else if (rsp_ready)
          state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_reg == FULL);
  end

  // Result, tag and priority pointer only move on an accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_sum_reg    <= '0;
      rsp_id_reg     <= '0;
      last_grant_reg <= IDW'(N-1);
      op_count_reg   <= '0;
    end else if (fire) begin
      rsp_sum_reg    <= adder_sum;
      rsp_id_reg     <= win_id;
      last_grant_reg <= win_id;
      op_count_reg   <= op_count_reg + 16'd1;
    end
  end

  assign rsp_sum  = rsp_sum_reg;
  assign rsp_id   = rsp_id_reg;
  assign op_count = op_count_reg;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one `adder32` instance (32-bit operands, 33-bit sum) among `N` requesters. Each requester presents an operand pair over a valid/ready handshake. The arbiter grants one pair per cycle, captures the 33-bit sum in a single-entry output register tagged with the requester ID, and presents it downstream over a second valid/ready handshake. It sits between the client blocks that need addition and the shared adder.

## Interface
- `N`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(N)`: width of the requester ID (derived; not overridden).
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-low reset. `rst`=0 at a rising edge resets the block.
- `req_valid`  in  N  bit i is 1 when requester i presents an operand pair.
- `req_ready`  out  N  one-hot or zero; bit i is 1 when requester i's pair is accepted this cycle.
- `req_a`  in  32*N  operand a; requester i uses bits [32i+31:32i].
- `req_b`  in  32*N  operand b; same packing as `req_a`.
- `rsp_valid`  out  1  output register holds a result.
- `rsp_ready`  in  1  downstream consumes the result this cycle.
- `rsp_sum`  out  33  registered result a+b, zero-extended with no truncation; bit 32 is the carry.
- `rsp_id`  out  IDW  index of the requester that produced `rsp_sum`.
- `op_count`  out  16  number of accepted requests; wraps modulo 2^16.

## Operation
- Instantiates one `adder32`. Its inputs are driven by a combinational mux from the granted requester's `req_a`/`req_b`.
- `can_accept` = !`rsp_valid` || `rsp_ready`. The single-entry output register is therefore pipelined: it may drain and refill in the same cycle.
- Grant is combinational, round-robin:
  - Priority order is `last_grant`+1, `last_grant`+2, ... (mod N).
  - The first requester in that order with `req_valid`=1 wins.
  - `req_ready`[win]=1 only if `can_accept`. All other `req_ready` bits are 0.
- Handshake on requester i fires when `req_valid`[i] && `req_ready`[i]. On that clock edge:
  - `rsp_sum` <= adder sum
  - `rsp_id` <= i
  - `rsp_valid` <= 1
  - `last_grant` <= i
  - `op_count` <= `op_count`+1
- If `rsp_valid` && `rsp_ready` and no request handshake fires, `rsp_valid` <= 0.
- If `rsp_valid` && !`rsp_ready`, `rsp_sum`, `rsp_id` and `rsp_valid` hold unchanged.
- `last_grant` changes only on a handshake. An idle cycle does not rotate priority.
- Requester rule: once `req_valid`[i] rises, `req_valid` and the operands stay stable until the handshake. The block does not check this; it is a bench assertion.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. No path runs from `req_ready` back to `req_valid` inside the block.
- States are implicit: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY -> FULL on a handshake.
  - FULL -> FULL on a handshake while `rsp_ready`=1, or while stalled.
  - FULL -> EMPTY on `rsp_ready`=1 with no handshake.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `op_count`=0.
  - `last_grant`=N-1, so requester 0 has first priority.
  - While `rst`=0, `req_ready` is forced to all-zero.
- Latency: a handshake at edge k makes the result visible with `rsp_valid`=1 after edge k; it can be consumed at edge k+1.
- Throughput: one request per cycle while `rsp_ready` is held at 1.
- Stall: while FULL and `rsp_ready`=0, `req_ready` is all-zero. No request is lost or duplicated.
- Reset mid-operation: a pending or held result is discarded. No handshake fires in the reset cycle. The first grant after reset goes to the lowest-indexed valid requester.
- `op_count` wraps 0xFFFF -> 0x0000 with no flag.
- Overflow: 0xFFFFFFFF + 0xFFFFFFFF gives `rsp_sum`=0x1_FFFF_FFFE. The carry always appears in bit 32.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with all `req_valid`=1 -> `req_ready`=0, `rsp_valid`=0, `op_count`=0 throughout. After release, the first grant goes to requester 0.
- Single requester 2:
  - a=0, b=0 -> one cycle later `rsp_valid`=1, `rsp_sum`=0, `rsp_id`=2.
  - Then a=b=0x80000000 -> `rsp_sum`=0x1_0000_0000.
- All 4 requesters valid continuously with `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0,1,... with one result per cycle; `op_count` increments every cycle.
- Only requesters 1 and 3 valid -> alternating grants 1,3,1,3. Dropping requester 3 gives 1,1,1 with no idle cycles.
- Backpressure: `rsp_ready`=0 for 3 cycles while FULL -> `rsp_sum`/`rsp_id` held and `req_ready`=0. On `rsp_ready`=1 the next request is accepted in that same cycle.
- Random: 1000 requests with random valid/ready patterns, checked against a 33-bit a+b scoreboard per ID. Include one reset asserted mid-stream -> no stale response after reset, and `op_count` restarts from 0.
